run_ctrl: RTL and testbench

Run controller on the CPU side of the Start/Ack handshake that the CPU benches drive. It arms the PC at a program entry point, enables execution, counts execution cycles, and raises Ack when the datapath decodes a halt instruction or a cycle budget runs out. It sits between the top-level `Reset`/`Start`/`Ack` pins and the PC/fetch stage. It selects one of three programs in rotation.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/cycle_counter.sv | 33 +++
 rtl/run_ctrl.sv | 97 +++++++++
 tb/tb_run_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU run controller.
package cpu_pkg;

  localparam int PC_W  = 11;  // program counter width
  localparam int SEL_W = 2;   // program-select width (programs 0..2)
  localparam int CNT_W = 32;  // execution-cycle counter width

  localparam logic [SEL_W-1:0] LAST_PROG = 2'd2;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } run_state_e;

  // Rotate through programs 0 -> 1 -> 2 -> 0.
  function automatic logic [SEL_W-1:0] next_prog(input logic [SEL_W-1:0] sel);
    return (sel == LAST_PROG) ? '0 : sel + 2'd1;
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Execution-cycle counter: clears on request, counts while enabled,
// holds its value otherwise, and flags the last budgeted cycle.
module cycle_counter
  import cpu_pkg::*;
#(
  parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // Count register: reset/clear to zero, increment when enabled, else freeze.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Terminal count: this enabled cycle is the last one the budget allows.
  assign o_tc    = (r_count == (MAX_CYCLES - 32'd1));
  assign o_count = r_count;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: arms the PC at a program entry, enables execution, counts
// RUN cycles and raises Ack on halt or budget exhaustion. Programs rotate 0/1/2.
module run_ctrl #(
  parameter int                PC_W       = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0]   ENTRY0     = '0,
  parameter logic [PC_W-1:0]   ENTRY1     = '0,
  parameter logic [PC_W-1:0]   ENTRY2     = '0,
  parameter logic [31:0]       MAX_CYCLES = 32'd100000
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic                        Halt,
  output logic                        PcInit,
  output logic [PC_W-1:0]             PcInitAddr,
  output logic                        RunEn,
  output logic                        Ack,
  output logic [cpu_pkg::SEL_W-1:0]   ProgSel,
  output logic [cpu_pkg::CNT_W-1:0]   CycleCount,
  output logic                        TimedOut
);

  import cpu_pkg::*;

  run_state_e       r_state;
  run_state_e       w_next_state;
  logic [SEL_W-1:0] r_prog_sel;
  logic             r_timed_out;
  logic             w_running;
  logic             w_rearm;
  logic             w_tc;

  assign w_running = (r_state == ST_RUN);
  assign w_rearm   = (r_state == ST_DONE) && Start;

  cycle_counter #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cycle_counter (
    .i_clk   (Clk),
    .i_reset (Reset),
    .i_clr   (w_rearm),
    .i_en    (w_running),
    .o_count (CycleCount),
    .o_tc    (w_tc)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_ARM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: Start holds ARM, halt beats budget in RUN, Start re-arms from DONE.
  // NOTE: default assigned first so no path leaves the output unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_ARM:  if (!Start)          w_next_state = ST_RUN;
      ST_RUN:  if (Halt || w_tc)    w_next_state = ST_DONE;
      ST_DONE: if (Start)           w_next_state = ST_ARM;
      default:                      w_next_state = ST_ARM;
    endcase
  end

  // Program select and timeout flag: advance/clear on re-arm, flag budget-only endings.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_prog_sel  <= '0;
      r_timed_out <= 1'b0;
    end else if (w_rearm) begin
      r_prog_sel  <= next_prog(r_prog_sel);
      r_timed_out <= 1'b0;
    end else if (w_running && !Halt && w_tc) begin
      r_timed_out <= 1'b1;
    end
  end

  // Moore outputs and entry-address mux.
  always_comb begin
    PcInit     = (r_state == ST_ARM);
    RunEn      = (r_state == ST_RUN);
    Ack        = (r_state == ST_DONE);
    PcInitAddr = ENTRY2;
    case (r_prog_sel)
      2'd0:    PcInitAddr = ENTRY0;
      2'd1:    PcInitAddr = ENTRY1;
      default: PcInitAddr = ENTRY2;
    endcase
  end

  assign ProgSel  = r_prog_sel;
  assign TimedOut = r_timed_out;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: two instances (long and 8-cycle budgets) driven in
// lockstep by directed and random stimulus, checked against a program-level model.
module tb_run_ctrl;

  localparam logic [10:0] A_E0 = 11'd5,  A_E1 = 11'd200, A_E2 = 11'd1234;
  localparam logic [10:0] B_E0 = 11'd17, B_E1 = 11'd300, B_E2 = 11'd2047;
  localparam int A_MAX = 100000;
  localparam int B_MAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance inputs: index 0 = A, index 1 = B.
  logic [1:0] rst, start, halt;

  logic        a_PcInit, a_RunEn, a_Ack, a_TimedOut;
  logic [10:0] a_PcInitAddr;
  logic [1:0]  a_ProgSel;
  logic [31:0] a_CycleCount;
  logic        b_PcInit, b_RunEn, b_Ack, b_TimedOut;
  logic [10:0] b_PcInitAddr;
  logic [1:0]  b_ProgSel;
  logic [31:0] b_CycleCount;

  run_ctrl #(.PC_W(11), .ENTRY0(A_E0), .ENTRY1(A_E1), .ENTRY2(A_E2),
             .MAX_CYCLES(32'(A_MAX))) dut_a (
    .Clk(clk), .Reset(rst[0]), .Start(start[0]), .Halt(halt[0]),
    .PcInit(a_PcInit), .PcInitAddr(a_PcInitAddr), .RunEn(a_RunEn), .Ack(a_Ack),
    .ProgSel(a_ProgSel), .CycleCount(a_CycleCount), .TimedOut(a_TimedOut)
  );

  run_ctrl #(.PC_W(11), .ENTRY0(B_E0), .ENTRY1(B_E1), .ENTRY2(B_E2),
             .MAX_CYCLES(32'(B_MAX))) dut_b (
    .Clk(clk), .Reset(rst[1]), .Start(start[1]), .Halt(halt[1]),
    .PcInit(b_PcInit), .PcInitAddr(b_PcInitAddr), .RunEn(b_RunEn), .Ack(b_Ack),
    .ProgSel(b_ProgSel), .CycleCount(b_CycleCount), .TimedOut(b_TimedOut)
  );

  // Program-level model: is a program being armed, executing, or finished.
  localparam int PH_ARM = 0, PH_EXEC = 1, PH_FINISHED = 2;
  int          m_phase [2];
  int          m_prog  [2];
  int          m_cyc   [2];
  bit          m_to    [2];
  int          m_max   [2];
  logic [10:0] m_entry [2][3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs just sampled.
  task automatic model_step(input int d);
    if (rst[d]) begin
      m_phase[d] = PH_ARM; m_prog[d] = 0; m_cyc[d] = 0; m_to[d] = 0;
    end else if (m_phase[d] == PH_ARM) begin
      if (!start[d]) m_phase[d] = PH_EXEC;
    end else if (m_phase[d] == PH_EXEC) begin
      m_cyc[d] = m_cyc[d] + 1;
      if (halt[d]) begin
        m_phase[d] = PH_FINISHED; m_to[d] = 0;
      end else if (m_cyc[d] == m_max[d]) begin
        m_phase[d] = PH_FINISHED; m_to[d] = 1;
      end
    end else begin
      if (start[d]) begin
        m_phase[d] = PH_ARM; m_prog[d] = (m_prog[d] + 1) % 3; m_cyc[d] = 0; m_to[d] = 0;
      end
    end
  endtask

  task automatic check_dut(input int d, input string tag);
    logic        pi, re, ak, to;
    logic [10:0] ad;
    logic [1:0]  ps;
    logic [31:0] cc;
    if (d == 0) begin
      pi = a_PcInit; re = a_RunEn; ak = a_Ack; to = a_TimedOut;
      ad = a_PcInitAddr; ps = a_ProgSel; cc = a_CycleCount;
    end else begin
      pi = b_PcInit; re = b_RunEn; ak = b_Ack; to = b_TimedOut;
      ad = b_PcInitAddr; ps = b_ProgSel; cc = b_CycleCount;
    end
    chk({tag, ".PcInit"},     32'(pi), 32'(m_phase[d] == PH_ARM));
    chk({tag, ".RunEn"},      32'(re), 32'(m_phase[d] == PH_EXEC));
    chk({tag, ".Ack"},        32'(ak), 32'(m_phase[d] == PH_FINISHED));
    chk({tag, ".PcInitAddr"}, 32'(ad), 32'(m_entry[d][m_prog[d]]));
    chk({tag, ".ProgSel"},    32'(ps), 32'(m_prog[d]));
    chk({tag, ".CycleCount"}, cc,      32'(m_cyc[d]));
    chk({tag, ".TimedOut"},   32'(to), 32'(m_to[d]));
  endtask

  // One clock: edge, update model, then sample both DUTs away from the edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_dut(0, {tag, ".a"});
    check_dut(1, {tag, ".b"});
  endtask

  initial begin
    int run_a, run_b;
    logic [10:0] a_ent [3];
    a_ent[0] = A_E0; a_ent[1] = A_E1; a_ent[2] = A_E2;

    m_max[0] = A_MAX; m_max[1] = B_MAX;
    m_entry[0][0] = A_E0; m_entry[0][1] = A_E1; m_entry[0][2] = A_E2;
    m_entry[1][0] = B_E0; m_entry[1][1] = B_E1; m_entry[1][2] = B_E2;
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = PH_ARM; m_prog[d] = 0; m_cyc[d] = 0; m_to[d] = 0;
    end

    // Reset both instances for 4 cycles.
    rst = 2'b11; start = 2'b00; halt = 2'b00;
    for (int i = 0; i < 4; i++) cycle("reset");
    chk("reset.PcInit", 32'(a_PcInit), 32'd1);
    chk("reset.PcInitAddr", 32'(a_PcInitAddr), 32'd5);
    chk("reset.RunEn", 32'(a_RunEn), 32'd0);
    chk("reset.CycleCount", a_CycleCount, 32'd0);

    // Release with Start low; A halts on its 10th RUN cycle, B runs out of budget.
    rst = 2'b00;
    run_a = 0; run_b = 0;
    for (int i = 0; i <= 10; i++) begin
      halt = {1'b0, (i == 10)};
      cycle("first_run");
      run_a += int'(a_RunEn);
      run_b += int'(b_RunEn);
    end
    chk("halt.run_cycles", 32'(run_a), 32'd10);
    chk("halt.Ack", 32'(a_Ack), 32'd1);
    chk("halt.CycleCount", a_CycleCount, 32'd10);
    chk("halt.TimedOut", 32'(a_TimedOut), 32'd0);
    chk("budget.run_cycles", 32'(run_b), 32'd8);
    chk("budget.CycleCount", b_CycleCount, 32'd8);
    chk("budget.TimedOut", 32'(b_TimedOut), 32'd1);

    // Re-arm both. A: reset in 3rd RUN cycle then Start/Halt in ARM.
    // B: halt on the 8th RUN cycle, coinciding with the budget end.
    for (int i = 0; i < 12; i++) begin
      rst   = {1'b0, (i == 6)};
      start = {(i < 3), (i < 3) || (i >= 7)};
      halt  = {(i == 11), (i == 6) || (i == 8) || (i == 10)};
      cycle("rearm");
      if (i == 0) begin
        chk("rearm.Ack_falls", 32'(a_Ack), 32'd0);
        chk("rearm.ProgSel", 32'(a_ProgSel), 32'd1);
        chk("rearm.PcInitAddr", 32'(a_PcInitAddr), 32'd200);
      end
      if (i == 3) chk("rearm.run_starts", 32'(a_RunEn), 32'd1);
      if (i == 6) begin
        chk("midrun_reset.PcInit", 32'(a_PcInit), 32'd1);
        chk("midrun_reset.ProgSel", 32'(a_ProgSel), 32'd0);
        chk("midrun_reset.CycleCount", a_CycleCount, 32'd0);
      end
    end
    chk("arm_hold.PcInit", 32'(a_PcInit), 32'd1);
    chk("coincide.Ack", 32'(b_Ack), 32'd1);
    chk("coincide.CycleCount", b_CycleCount, 32'd8);
    chk("coincide.TimedOut", 32'(b_TimedOut), 32'd0);

    // Cycle A through four programs; B sits in ARM with Start high.
    rst = 2'b00;
    for (int k = 0; k < 4; k++) begin
      chk("rotate.ProgSel", 32'(a_ProgSel), 32'(k % 3));
      chk("rotate.PcInitAddr", 32'(a_PcInitAddr), 32'(a_ent[k % 3]));
      start = 2'b10; halt = 2'b00; cycle("rotate_go");
      start = 2'b10; halt = 2'b01; cycle("rotate_halt");
      start = 2'b11; halt = 2'b00; cycle("rotate_rearm");
    end

    // Random stimulus on both instances.
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 2; d++) begin
        rst[d]   = ($urandom_range(0, 99) == 0);
        start[d] = ($urandom_range(0, 2) == 0);
        halt[d]  = ($urandom_range(0, 7) == 0);
      end
      cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
